// File: rtl/issue_scheduler_if.sv
// Decode/writeback/flush bundle between the front end and the issue scheduler.
// The master side (decode, writeback network, flush control) drives the
// request signals; the slave side (scheduler) drives issue and status.
interface issue_scheduler_if #(
    parameter int REG_NUM = 16,
    parameter int REG_W   = 4,
    parameter int OP_W    = 4,
    parameter int CNT_W   = 8
);
    logic               grp_vld;
    logic               grp_rdy;
    logic               ins_in_1_vld, ins_in_2_vld, ins_in_3_vld, ins_in_4_vld;
    logic [REG_W-1:0]   ins_in_1_des, ins_in_2_des, ins_in_3_des, ins_in_4_des;
    logic [REG_W-1:0]   ins_in_1_source1, ins_in_2_source1, ins_in_3_source1, ins_in_4_source1;
    logic [REG_W-1:0]   ins_in_1_source2, ins_in_2_source2, ins_in_3_source2, ins_in_4_source2;
    logic [OP_W-1:0]    op1, op2, op3, op4;
    logic               ins_back_1_vld, ins_back_2_vld, ins_back_3_vld, ins_back_4_vld;
    logic [REG_W-1:0]   ins_back_1_des, ins_back_2_des, ins_back_3_des, ins_back_4_des;
    logic               flush_en;
    logic [REG_NUM-1:0] flush_reg;
    logic               ins1_out, ins2_out, ins3_out, ins4_out;
    logic               ins1_stall, ins2_stall, ins3_stall, ins4_stall;
    logic [REG_W-1:0]   iss_1_des, iss_2_des, iss_3_des, iss_4_des;
    logic [OP_W-1:0]    iss_1_op, iss_2_op, iss_3_op, iss_4_op;
    logic [REG_NUM-1:0] sb_busy;
    logic [CNT_W-1:0]   stall_cnt;

    modport master (
        output grp_vld,
        output ins_in_1_vld, ins_in_2_vld, ins_in_3_vld, ins_in_4_vld,
        output ins_in_1_des, ins_in_2_des, ins_in_3_des, ins_in_4_des,
        output ins_in_1_source1, ins_in_2_source1, ins_in_3_source1, ins_in_4_source1,
        output ins_in_1_source2, ins_in_2_source2, ins_in_3_source2, ins_in_4_source2,
        output op1, op2, op3, op4,
        output ins_back_1_vld, ins_back_2_vld, ins_back_3_vld, ins_back_4_vld,
        output ins_back_1_des, ins_back_2_des, ins_back_3_des, ins_back_4_des,
        output flush_en, flush_reg,
        input  grp_rdy,
        input  ins1_out, ins2_out, ins3_out, ins4_out,
        input  ins1_stall, ins2_stall, ins3_stall, ins4_stall,
        input  iss_1_des, iss_2_des, iss_3_des, iss_4_des,
        input  iss_1_op, iss_2_op, iss_3_op, iss_4_op,
        input  sb_busy, stall_cnt
    );

    modport slave (
        input  grp_vld,
        input  ins_in_1_vld, ins_in_2_vld, ins_in_3_vld, ins_in_4_vld,
        input  ins_in_1_des, ins_in_2_des, ins_in_3_des, ins_in_4_des,
        input  ins_in_1_source1, ins_in_2_source1, ins_in_3_source1, ins_in_4_source1,
        input  ins_in_1_source2, ins_in_2_source2, ins_in_3_source2, ins_in_4_source2,
        input  op1, op2, op3, op4,
        input  ins_back_1_vld, ins_back_2_vld, ins_back_3_vld, ins_back_4_vld,
        input  ins_back_1_des, ins_back_2_des, ins_back_3_des, ins_back_4_des,
        input  flush_en, flush_reg,
        output grp_rdy,
        output ins1_out, ins2_out, ins3_out, ins4_out,
        output ins1_stall, ins2_stall, ins3_stall, ins4_stall,
        output iss_1_des, iss_2_des, iss_3_des, iss_4_des,
        output iss_1_op, iss_2_op, iss_3_op, iss_4_op,
        output sb_busy, stall_cnt
    );
endinterface

// File: rtl/issue_scheduler.sv
// Four-wide in-order issue scheduler: holds one decoded group, tracks busy
// registers in a scoreboard and issues the longest hazard-free in-order
// prefix of the still-pending slots every cycle.
module issue_scheduler #(
    parameter int REG_NUM = 16,
    parameter int REG_W   = 4,
    parameter int OP_W    = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    issue_scheduler_if.slave   bus
);
    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t             r_state, w_state_next;
    logic [3:0]         r_pend, w_pend_next;
    logic [REG_W-1:0]   r_des [4];
    logic [REG_W-1:0]   r_src1 [4];
    logic [REG_W-1:0]   r_src2 [4];
    logic [OP_W-1:0]    r_op [4];
    logic [REG_NUM-1:0] r_sb, w_sb_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;

    logic [3:0]         w_in_vld;
    logic [REG_W-1:0]   w_in_des [4];
    logic [REG_W-1:0]   w_in_src1 [4];
    logic [REG_W-1:0]   w_in_src2 [4];
    logic [OP_W-1:0]    w_in_op [4];
    logic [3:0]         w_back_vld;
    logic [REG_W-1:0]   w_back_des [4];
    logic [REG_NUM-1:0] w_wb_mask, w_eff, w_set_mask, w_flush_mask;
    logic [3:0]         w_issue;
    logic               w_accept;

    assign w_in_vld     = {bus.ins_in_4_vld, bus.ins_in_3_vld, bus.ins_in_2_vld, bus.ins_in_1_vld};
    assign w_in_des     = '{bus.ins_in_1_des, bus.ins_in_2_des, bus.ins_in_3_des, bus.ins_in_4_des};
    assign w_in_src1    = '{bus.ins_in_1_source1, bus.ins_in_2_source1, bus.ins_in_3_source1, bus.ins_in_4_source1};
    assign w_in_src2    = '{bus.ins_in_1_source2, bus.ins_in_2_source2, bus.ins_in_3_source2, bus.ins_in_4_source2};
    assign w_in_op      = '{bus.op1, bus.op2, bus.op3, bus.op4};
    assign w_back_vld   = {bus.ins_back_4_vld, bus.ins_back_3_vld, bus.ins_back_2_vld, bus.ins_back_1_vld};
    assign w_back_des   = '{bus.ins_back_1_des, bus.ins_back_2_des, bus.ins_back_3_des, bus.ins_back_4_des};
    assign w_flush_mask = bus.flush_en ? bus.flush_reg : '0;
    assign w_accept     = (r_state == S_IDLE) && bus.grp_vld && !bus.flush_en && (|w_in_vld);

    // Writeback clear mask; same-cycle bypass into the effective busy view.
    always_comb begin
        w_wb_mask = '0;
        for (int k = 0; k < 4; k++) begin
            if (w_back_vld[k]) w_wb_mask[w_back_des[k]] = 1'b1;
        end
    end
    assign w_eff = r_sb & ~w_wb_mask;

    // In-order issue selection: a pending slot that cannot issue blocks all
    // higher slots; w_set_mask doubles as the intra-group RAW/WAW filter.
    always_comb begin
        logic blocked;
        w_issue    = '0;
        w_set_mask = '0;
        blocked    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (r_pend[k] && !bus.flush_en && !blocked) begin
                if (!w_eff[r_src1[k]] && !w_eff[r_src2[k]] && !w_eff[r_des[k]] &&
                    !w_set_mask[r_src1[k]] && !w_set_mask[r_src2[k]] && !w_set_mask[r_des[k]]) begin
                    w_issue[k]             = 1'b1;
                    w_set_mask[r_des[k]]   = 1'b1;
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    // Next-state, pending, scoreboard and stall counter.
    always_comb begin
        w_state_next = r_state;
        w_pend_next  = r_pend;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_pend_next  = w_in_vld;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.flush_en) begin
                    w_pend_next  = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_pend_next = r_pend & ~w_issue;
                    if (w_pend_next == 4'b0000) w_state_next = S_IDLE;
                end
            end
            default: begin
                w_pend_next  = '0;
                w_state_next = S_IDLE;
            end
        endcase
        // Set beats clear: the set mask is OR-ed in last.
        w_sb_next = (r_sb & ~w_wb_mask & ~w_flush_mask) | w_set_mask;
        w_cnt_next = '0;
        if ((r_state == S_ISSUE) && !bus.flush_en && (w_issue == 4'b0000))
            w_cnt_next = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    end

    // Control and scoreboard registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_sb    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
            r_sb    <= w_sb_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Group payload latch; only meaningful while the slot is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_des[k]  <= '0;
                r_src1[k] <= '0;
                r_src2[k] <= '0;
                r_op[k]   <= '0;
            end
        end else if (w_accept) begin
            r_des  <= w_in_des;
            r_src1 <= w_in_src1;
            r_src2 <= w_in_src2;
            r_op   <= w_in_op;
        end
    end

    assign bus.grp_rdy    = (r_state == S_IDLE);
    assign bus.sb_busy    = r_sb;
    assign bus.stall_cnt  = r_cnt;
    assign bus.ins1_out   = w_issue[0];
    assign bus.ins2_out   = w_issue[1];
    assign bus.ins3_out   = w_issue[2];
    assign bus.ins4_out   = w_issue[3];
    assign bus.ins1_stall = r_pend[0] & ~w_issue[0];
    assign bus.ins2_stall = r_pend[1] & ~w_issue[1];
    assign bus.ins3_stall = r_pend[2] & ~w_issue[2];
    assign bus.ins4_stall = r_pend[3] & ~w_issue[3];
    assign bus.iss_1_des  = w_issue[0] ? r_des[0] : '0;
    assign bus.iss_2_des  = w_issue[1] ? r_des[1] : '0;
    assign bus.iss_3_des  = w_issue[2] ? r_des[2] : '0;
    assign bus.iss_4_des  = w_issue[3] ? r_des[3] : '0;
    assign bus.iss_1_op   = w_issue[0] ? r_op[0] : '0;
    assign bus.iss_2_op   = w_issue[1] ? r_op[1] : '0;
    assign bus.iss_3_op   = w_issue[2] ? r_op[2] : '0;
    assign bus.iss_4_op   = w_issue[3] ? r_op[3] : '0;
endmodule

// File: tb/tb_issue_scheduler.sv
// Testbench for issue_scheduler: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_issue_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    issue_scheduler_if bus ();
    issue_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Stimulus image (driven onto the interface by apply()).
    logic       t_grp, t_flush;
    logic [15:0] t_freg;
    logic       t_vld [4];
    logic [3:0] t_des [4], t_s1 [4], t_s2 [4], t_op [4];
    logic       t_bvld [4];
    logic [3:0] t_bdes [4];

    // Reference model: pending slots kept as an ordered queue of indices.
    bit         m_busy [16];
    int         m_q [$];
    logic [3:0] m_des [4], m_s1 [4], m_s2 [4], m_op [4];
    int         m_cnt;

    logic [3:0] last_out, last_stall;
    logic [7:0] last_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        t_grp = 0; t_flush = 0; t_freg = '0;
        for (int k = 0; k < 4; k++) begin
            t_vld[k] = 0; t_des[k] = 0; t_s1[k] = 0; t_s2[k] = 0; t_op[k] = 0;
            t_bvld[k] = 0; t_bdes[k] = 0;
        end
    endtask

    task automatic set_slot(input int k, input logic [3:0] d, input logic [3:0] a, input logic [3:0] b);
        t_vld[k] = 1; t_des[k] = d; t_s1[k] = a; t_s2[k] = b; t_op[k] = 4'($urandom_range(0, 15));
    endtask

    task automatic apply();
        bus.grp_vld = t_grp; bus.flush_en = t_flush; bus.flush_reg = t_freg;
        bus.ins_in_1_vld = t_vld[0]; bus.ins_in_2_vld = t_vld[1]; bus.ins_in_3_vld = t_vld[2]; bus.ins_in_4_vld = t_vld[3];
        bus.ins_in_1_des = t_des[0]; bus.ins_in_2_des = t_des[1]; bus.ins_in_3_des = t_des[2]; bus.ins_in_4_des = t_des[3];
        bus.ins_in_1_source1 = t_s1[0]; bus.ins_in_2_source1 = t_s1[1]; bus.ins_in_3_source1 = t_s1[2]; bus.ins_in_4_source1 = t_s1[3];
        bus.ins_in_1_source2 = t_s2[0]; bus.ins_in_2_source2 = t_s2[1]; bus.ins_in_3_source2 = t_s2[2]; bus.ins_in_4_source2 = t_s2[3];
        bus.op1 = t_op[0]; bus.op2 = t_op[1]; bus.op3 = t_op[2]; bus.op4 = t_op[3];
        bus.ins_back_1_vld = t_bvld[0]; bus.ins_back_2_vld = t_bvld[1]; bus.ins_back_3_vld = t_bvld[2]; bus.ins_back_4_vld = t_bvld[3];
        bus.ins_back_1_des = t_bdes[0]; bus.ins_back_2_des = t_bdes[1]; bus.ins_back_3_des = t_bdes[2]; bus.ins_back_4_des = t_bdes[3];
    endtask

    task automatic model_reset();
        for (int r = 0; r < 16; r++) m_busy[r] = 0;
        m_q.delete();
        m_cnt = 0;
    endtask

    // One clock cycle: drive, compare at the falling edge, advance model, step.
    task automatic cycle_check();
        bit eff [16];
        bit wr [16];
        logic [3:0] pend_b, exp_out, exp_stall, obs_out, obs_stall;
        logic [3:0] obs_des [4], obs_op [4];
        logic [15:0] exp_sb;
        bit any_vld;
        int k;
        apply();
        @(negedge clk);
        pend_b = 0;
        foreach (m_q[i]) pend_b[m_q[i]] = 1;
        for (int r = 0; r < 16; r++) begin eff[r] = m_busy[r]; wr[r] = 0; end
        for (int b = 0; b < 4; b++) if (t_bvld[b]) eff[t_bdes[b]] = 0;
        exp_out = 0;
        if (!t_flush) begin
            for (int i = 0; i < m_q.size(); i++) begin
                k = m_q[i];
                if (eff[m_s1[k]] || eff[m_s2[k]] || eff[m_des[k]] ||
                    wr[m_s1[k]] || wr[m_s2[k]] || wr[m_des[k]]) break;
                exp_out[k] = 1;
                wr[m_des[k]] = 1;
            end
        end
        exp_stall = pend_b & ~exp_out;
        exp_sb = '0;
        for (int r = 0; r < 16; r++) exp_sb[r] = m_busy[r];

        obs_out   = {bus.ins4_out, bus.ins3_out, bus.ins2_out, bus.ins1_out};
        obs_stall = {bus.ins4_stall, bus.ins3_stall, bus.ins2_stall, bus.ins1_stall};
        obs_des   = '{bus.iss_1_des, bus.iss_2_des, bus.iss_3_des, bus.iss_4_des};
        obs_op    = '{bus.iss_1_op, bus.iss_2_op, bus.iss_3_op, bus.iss_4_op};
        chk("grp_rdy", 32'(bus.grp_rdy), 32'(pend_b == 0));
        chk("ins_out", 32'(obs_out), 32'(exp_out));
        chk("ins_stall", 32'(obs_stall), 32'(exp_stall));
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("iss_%0d_des", s + 1), 32'(obs_des[s]), 32'(exp_out[s] ? m_des[s] : 4'd0));
            chk($sformatf("iss_%0d_op", s + 1), 32'(obs_op[s]), 32'(exp_out[s] ? m_op[s] : 4'd0));
        end
        chk("sb_busy", 32'(bus.sb_busy), 32'(exp_sb));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
        last_out = obs_out; last_stall = obs_stall; last_cnt = bus.stall_cnt;
        $display("t=%0t rst=%0b grp=%0b fl=%0b out=%b stall=%b sb=%h cnt=%0d",
                 $time, rst, t_grp, t_flush, obs_out, obs_stall, bus.sb_busy, bus.stall_cnt);

        if (rst) begin
            model_reset();
        end else begin
            for (int r = 0; r < 16; r++) begin
                m_busy[r] = eff[r];
                if (t_flush && t_freg[r]) m_busy[r] = 0;
                if (wr[r]) m_busy[r] = 1;
            end
            if (pend_b != 0 && !t_flush && exp_out == 0) m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
            else m_cnt = 0;
            if (t_flush) m_q.delete();
            else while (m_q.size() > 0 && exp_out[m_q[0]]) void'(m_q.pop_front());
            any_vld = t_vld[0] | t_vld[1] | t_vld[2] | t_vld[3];
            if (pend_b == 0 && t_grp && !t_flush && any_vld) begin
                for (int s = 0; s < 4; s++) begin
                    m_des[s] = t_des[s]; m_s1[s] = t_s1[s]; m_s2[s] = t_s2[s]; m_op[s] = t_op[s];
                    if (t_vld[s]) m_q.push_back(s);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wb_clear(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        clr();
        t_bvld = '{1, 1, 1, 1};
        t_bdes = '{a, b, c, d};
        cycle_check();
        clr();
    endtask

    initial begin
        rst = 1;
        clr();
        apply();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cycle_check();                // still in reset: reset values
        rst = 0;
        cycle_check();
        chk("reset_rdy", 32'(bus.grp_rdy), 32'd1);
        chk("reset_sb", 32'(bus.sb_busy), 32'h0);

        // Independent group
        clr(); t_grp = 1;
        set_slot(0, 1, 0, 0); set_slot(1, 2, 0, 0); set_slot(2, 3, 0, 0); set_slot(3, 4, 0, 0);
        cycle_check();
        clr(); cycle_check();
        chk("indep_all_out", 32'(last_out), 32'hF);
        chk("indep_sb", 32'(bus.sb_busy), 32'h001E);
        chk("indep_rdy", 32'(bus.grp_rdy), 32'd1);
        wb_clear(1, 2, 3, 4);

        // Intra-group RAW
        clr(); t_grp = 1;
        set_slot(0, 5, 0, 0); set_slot(1, 6, 5, 0); set_slot(2, 8, 0, 0); set_slot(3, 9, 0, 0);
        cycle_check();
        clr(); cycle_check();
        chk("raw_out", 32'(last_out), 32'h1);
        chk("raw_stall", 32'(last_stall), 32'hE);
        chk("raw_sb5", 32'(bus.sb_busy[5]), 32'd1);
        repeat (3) cycle_check();
        chk("raw_cnt3", 32'(bus.stall_cnt), 32'd3);
        clr(); t_bvld[0] = 1; t_bdes[0] = 5;
        cycle_check();
        chk("raw_bypass_out", 32'(last_out), 32'hE);
        chk("raw_cnt_clr", 32'(bus.stall_cnt), 32'd0);
        wb_clear(6, 8, 9, 9);

        // Set/clear collision
        clr(); t_grp = 1; set_slot(0, 7, 0, 0);
        cycle_check();
        clr(); t_bvld[0] = 1; t_bdes[0] = 7;
        cycle_check();
        chk("collide_sb7", 32'(bus.sb_busy[7]), 32'd1);
        wb_clear(7, 7, 7, 7);

        // Flush mid-group
        clr(); t_grp = 1;
        set_slot(0, 4, 0, 0); set_slot(1, 5, 0, 0); set_slot(2, 6, 0, 0); set_slot(3, 7, 0, 0);
        cycle_check();
        clr(); cycle_check();
        chk("flush_pre_sb", 32'(bus.sb_busy), 32'h00F0);
        clr(); t_grp = 1; set_slot(0, 10, 4, 0); set_slot(1, 11, 0, 0);
        cycle_check();
        clr(); cycle_check();
        chk("flush_pending", 32'(last_stall), 32'h3);
        clr(); t_flush = 1; t_freg = 16'h0030; t_grp = 1; set_slot(0, 12, 0, 0);
        cycle_check();
        chk("flush_no_issue", 32'(last_out), 32'h0);
        chk("flush_sb", 32'(bus.sb_busy), 32'h00C0);
        chk("flush_rdy", 32'(bus.grp_rdy), 32'd1);
        clr(); t_flush = 1; t_freg = 16'hFFFF; t_grp = 1; set_slot(0, 12, 0, 0);
        cycle_check();
        chk("flush_idle_not_acc", 32'(bus.grp_rdy), 32'd1);
        chk("flush_all_sb", 32'(bus.sb_busy), 32'h0);

        // Sparse and all-invalid groups
        clr(); t_grp = 1; set_slot(2, 2, 3, 4);
        cycle_check();
        clr(); cycle_check();
        chk("sparse_out", 32'(last_out), 32'h4);
        wb_clear(2, 2, 2, 2);
        clr(); t_grp = 1;
        cycle_check();
        chk("empty_grp_idle", 32'(bus.grp_rdy), 32'd1);
        clr(); cycle_check();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            clr();
            t_grp = ($urandom_range(0, 1) == 1);
            for (int s = 0; s < 4; s++) begin
                if ($urandom_range(0, 9) < 7)
                    set_slot(s, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
                t_bvld[s] = ($urandom_range(0, 9) < 3);
                t_bdes[s] = 4'($urandom_range(0, 7));
            end
            t_flush = ($urandom_range(0, 19) == 0);
            t_freg  = 16'($urandom());
            rst     = ($urandom_range(0, 99) == 0);
            cycle_check();
            rst = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
